add32_share_arbiter: RTL and testbench
======================================

// Module: add32_share_arbiter
// PURPOSE
//  Shares one Add32 adder/subtractor instance between N_REQ requesters. Round-robin
//  arbitration, operand latching, single-issue sequencing, one tagged response channel.
//  Sits between the client blocks and the Add32 datapath; clients never drive Add32 directly.
// PARAMETERS
//  N_REQ   4  number of requesters (2..8)
//  ID_W    2  width of rsp_id; must equal clog2(N_REQ)
// PORTS
//  clk           in   1         single clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  req_valid     in   N_REQ     per-requester operation request
//  req_ready     out  N_REQ     one-hot grant; handshake = req_valid[i] & req_ready[i]
//  req_a         in   N_REQ*32  operand A, requester i at [32*i+31:32*i]
//  req_b         in   N_REQ*32  operand B, same packing
//  req_sub       in   N_REQ     1 = A-B, 0 = A+B
//  req_sign      in   N_REQ     1 = signed overflow rule, 0 = unsigned
//  rsp_valid     out  1         response available
//  rsp_ready     in   1         response accepted
//  rsp_id        out  ID_W      index of requester that owns the response
//  rsp_result    out  32        Add32 result
//  rsp_overflow  out  1         Add32 Overflow
//  busy          out  1         high in EXEC or RESP
// BEHAVIOUR
//  - FSM IDLE -> EXEC -> RESP -> IDLE. Reset: IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0,
//    rsp_result=0, rsp_overflow=0, busy=0, req_ready=0 (forced 0 while rst_n low).
//  - IDLE: grant = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    req_ready = one-hot(grant), combinational from req_valid; 0 if none valid.
//    On handshake latch a/b/sub/sign/id of grantee, go EXEC. Other requesters wait (no drop).
//  - EXEC (1 cycle): latched operands drive Add32; at edge capture result/Overflow into
//    rsp regs, go RESP. req_ready = 0 in EXEC and RESP.
//  - RESP: rsp_valid=1; rsp_id/result/overflow held stable until rsp_ready. On
//    rsp_valid & rsp_ready: rsp_valid=0, rr_ptr = (id+1) mod N_REQ, go IDLE.
//  - Latency: handshake in cycle c -> rsp_valid high in c+2. Max throughput 1 op / 3 cycles.
//  - Arithmetic purely Add32: 32-bit wrap-around result; Overflow = carry-out (unsigned add),
//    borrow (unsigned sub), two's-complement overflow (signed). No saturation.
//  - Fairness: requester holding req_valid is granted within N_REQ transactions.
//  - Requester may drop req_valid before grant; no effect. Operands sampled only at handshake.
//  - rsp_ready low indefinitely: stays in RESP, no new grants.
//  - Reset mid-operation: in-flight transaction discarded, no response ever issued.
// CONFIGURATION
//  - Macro ADD32_ARB_OVF_STICKY_EN defined: adds ports ovf_sticky out N_REQ and
//    ovf_clr in N_REQ. ovf_sticky[i] set at the RESP->IDLE handshake when rsp_id==i and
//    rsp_overflow=1; cleared by ovf_clr[i]=1; same-cycle set and clear -> set wins. Reset 0.
//  - Macro undefined: those ports and registers do not exist; all other behaviour identical.
// STRUCTURE
//  - Package add32_arb_pkg: state encoding (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2),
//    DATA_W=32 constant, round-robin next-grant function.
//  - One sub-module instance: Add32 (existing), port order (Overflow, result, A, B, isSub, isSign).
//  - Arbiter is inline logic, no separate module.
// TESTING
//  1. Single req0: A=100, B=100, add, unsigned -> rsp_id=0, result=200, overflow=0, rsp_valid at c+2.
//  2. req1: A=32'hFFFF_FFFF, B=1, add, unsigned -> result=0, overflow=1; signed -> overflow=0.
//  3. req2: A=32'h7FFF_FFFF, B=1, add, signed -> result=32'h8000_0000, overflow=1;
//     A=0, B=1, sub, unsigned -> result=32'hFFFF_FFFF, overflow=1.
//  4. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each id once per 4 ops.
//  5. rsp_ready low 10 cycles in RESP -> rsp_* stable, req_ready=0; accepted on first rsp_ready=1.
//  6. rst_n low during EXEC -> rsp_valid stays 0, state IDLE, rr_ptr=0; with ADD32_ARB_OVF_STICKY_EN,
//     overflow on id 1 sets ovf_sticky[1]; simultaneous ovf_clr[1] with new overflow keeps it 1.

Source files
------------

// File: rtl/add32_arb_pkg.sv
// Shared types, constants and the round-robin grant helper for add32_share_arbiter.
package add32_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned N_MAX  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Operand payload latched at the request handshake.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              sign;
  } op_t;

  // Returns {found, index}: first set bit of valid[n-1:0] scanning ptr, ptr+1, ... mod n.
  function automatic logic [3:0] rr_next_grant(input logic [N_MAX-1:0] valid,
                                               input logic [2:0]       ptr,
                                               input int unsigned      n);
    logic [3:0]  res;
    int unsigned idx;
    res = 4'd0;
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int unsigned k = N_MAX; k > 0; k--) begin
      if (k <= n) begin
        idx = (32'(ptr) + k - 1) % n;
        if (valid[3'(idx)]) res = {1'b1, 3'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/add32_share_arbiter_add32.sv
// Add32: 32-bit adder/subtractor with unsigned carry/borrow or signed overflow flag.
module Add32
  import add32_arb_pkg::*;
(
  output logic              Overflow,
  output logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              isSub,
  input  logic              isSign
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] b_eff;

  // Subtraction as A + ~B + 1; flag chosen by signedness and direction.
  always_comb begin
    b_eff  = isSub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_eff} + (DATA_W + 1)'(isSub);
    result = sum[DATA_W-1:0];
    if (isSign) begin
      Overflow = (A[DATA_W-1] == b_eff[DATA_W-1]) && (result[DATA_W-1] != A[DATA_W-1]);
    end else begin
      Overflow = isSub ? ~sum[DATA_W] : sum[DATA_W];
    end
  end

endmodule

// File: rtl/add32_share_arbiter.sv
// add32_share_arbiter: round-robin sharing of one Add32 among N_REQ requesters.
// Optional macro ADD32_ARB_OVF_STICKY_EN adds per-requester sticky overflow flags.
module add32_share_arbiter
  import add32_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic [N_REQ-1:0]        req_sub,
  input  logic [N_REQ-1:0]        req_sign,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_overflow,
  output logic                    busy
`ifdef ADD32_ARB_OVF_STICKY_EN
  ,
  output logic [N_REQ-1:0]        ovf_sticky,
  input  logic [N_REQ-1:0]        ovf_clr
`endif
);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              hs;
  logic              rsp_done;
  op_t               op_q;
  logic [ID_W-1:0]   id_q;
  logic [DATA_W-1:0] add_res;
  logic              add_ovf;

  // Round-robin pick among current requesters.
  always_comb begin
    gnt    = rr_next_grant(N_MAX'(req_valid), 3'(rr_ptr), N_REQ);
    gnt_id = ID_W'(gnt[2:0]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, grant and handshake decode.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    hs        = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rst_n && gnt[3]) begin
          req_ready[gnt_id] = 1'b1;
          hs                = 1'b1;
          state_nxt         = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  Add32 u_add32 (
    .Overflow (add_ovf),
    .result   (add_res),
    .A        (op_q.a),
    .B        (op_q.b),
    .isSub    (op_q.sub),
    .isSign   (op_q.sign)
  );

  // Operand latch, response registers, round-robin pointer and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      id_q         <= '0;
      rr_ptr       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy      <= (state_nxt != ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
      if (hs) begin
        op_q.a    <= req_a[DATA_W*gnt_id +: DATA_W];
        op_q.b    <= req_b[DATA_W*gnt_id +: DATA_W];
        op_q.sub  <= req_sub[gnt_id];
        op_q.sign <= req_sign[gnt_id];
        id_q      <= gnt_id;
      end
      if (state == ST_EXEC) begin
        rsp_result   <= add_res;
        rsp_overflow <= add_ovf;
        rsp_id       <= id_q;
      end
      if (rsp_done) begin
        rr_ptr <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
      end
    end
  end

`ifdef ADD32_ARB_OVF_STICKY_EN
  logic [N_REQ-1:0] ovf_set;

  // Sticky set request from the accepted response; set dominates clear.
  always_comb begin
    ovf_set = '0;
    if (rsp_done && rsp_overflow) ovf_set[rsp_id] = 1'b1;
  end

  // Per-requester sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= '0;
    else        ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set;
  end
`endif

endmodule

// File: tb/tb_add32_share_arbiter.sv
// Self-checking bench for add32_share_arbiter: reference model plus directed literal checks.
module tb_add32_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N-1:0]    req_sub;
  logic [N-1:0]    req_sign;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_overflow;
  logic            busy;
`ifdef ADD32_ARB_OVF_STICKY_EN
  logic [N-1:0]    ovf_sticky;
  logic [N-1:0]    ovf_clr;
`endif

  add32_share_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .req_sign     (req_sign),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
`ifdef ADD32_ARB_OVF_STICKY_EN
    ,
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference from the numeric definition of each overflow rule.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                   input bit sub, input bit sign,
                                   output logic [31:0] r, output bit o);
    longint sa, sb, sr, ua, ub, hi, lo;
    hi = 2147483647;
    lo = -hi - 1;
    r  = sub ? a - b : a + b;
    if (sign) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = sub ? sa - sb : sa + sb;
      o  = (sr > hi) || (sr < lo);
    end else begin
      ua = longint'(a);
      ub = longint'(b);
      o  = sub ? (ua < ub) : ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
    end
  endfunction

  // Model state: one outstanding op, its age in cycles since the handshake edge.
  bit          m_busy;
  int          m_age;
  int          m_ptr;
  int          m_id;
  logic [31:0] m_res;
  bit          m_ovf;
  logic [N-1:0] m_sticky;

  // Compare DUT to model every falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           g;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk("rst_rsp_result", 64'(rsp_result), 64'(0));
      chk("rst_rsp_overflow", 64'(rsp_overflow), 64'(0));
`ifdef ADD32_ARB_OVF_STICKY_EN
      chk("rst_ovf_sticky", 64'(ovf_sticky), 64'(0));
`endif
      m_busy   = 1'b0;
      m_age    = 0;
      m_ptr    = 0;
      m_sticky = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (req_valid[2'((m_ptr + k) % N)]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0) exp_rdy[2'(g)] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_result", 64'(rsp_result), 64'(m_res));
        chk("rsp_overflow", 64'(rsp_overflow), 64'(m_ovf));
      end
`ifdef ADD32_ARB_OVF_STICKY_EN
      chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
      m_sticky = m_sticky & ~ovf_clr;
`endif
      if (m_busy) begin
        if (m_age >= 2 && rsp_ready) begin
          m_busy = 1'b0;
          m_ptr  = (m_id + 1) % N;
          if (m_ovf) m_sticky[2'(m_id)] = 1'b1;
        end else if (m_age < 2) begin
          m_age++;
        end
      end else if (g >= 0) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_id   = g;
        model_op(req_a[g*32 +: 32], req_b[g*32 +: 32], req_sub[2'(g)], req_sign[2'(g)],
                 m_res, m_ovf);
      end
    end
  end

  // One request on one port with literal expectations, including handshake-to-valid latency.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input bit sub, input bit sign,
                       input logic [31:0] er, input bit eo, input string name);
    int w;
    @(posedge clk); #1;
    req_valid[id]       = 1'b1;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
    req_sub[id]         = sub;
    req_sign[id]        = sign;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready[id] && w < 20);
    chk({name, "_grant"}, 64'(req_ready[id]), 64'(1));
    @(posedge clk); #1;
    req_valid[id]      = 1'b0;
    req_a[id*32 +: 32] = 32'hDEAD_BEEF;
    req_b[id*32 +: 32] = 32'h1234_5678;
    w = 0;
    do begin @(negedge clk); w++; end while (!rsp_valid && w < 20);
    chk({name, "_latency"}, 64'(w), 64'(2));
    chk({name, "_id"}, 64'(rsp_id), 64'(id));
    chk({name, "_result"}, 64'(rsp_result), 64'(er));
    chk({name, "_overflow"}, 64'(rsp_overflow), 64'(eo));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int ids[5];
    int w;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
`ifdef ADD32_ARB_OVF_STICKY_EN
    ovf_clr   = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic arithmetic and flag rules.
    do_op(0, 32'd100, 32'd100, 1'b0, 1'b0, 32'd200, 1'b0, "t1_add");
    do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "t2_uadd_carry");
    do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, "t2_sadd");
    do_op(2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, "t3_sadd_ovf");
    do_op(2, 32'd0, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, "t3_usub_borrow");
    do_op(3, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, "ssub_ovf");
    do_op(3, 32'd5, 32'd3, 1'b1, 1'b0, 32'd2, 1'b0, "usub_plain");

    // All requesters active from pointer 0: grant order 0,1,2,3,0.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = 32'(i * 16 + 1);
      req_b[i*32 +: 32] = 32'(i);
    end
    req_sub   = '0;
    req_sign  = '0;
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!rsp_valid && w < 20);
      ids[t] = int'(rsp_id);
      @(posedge clk);
    end
    #1 req_valid = '0;
    chk("rr_order_0", 64'(ids[0]), 64'(0));
    chk("rr_order_1", 64'(ids[1]), 64'(1));
    chk("rr_order_2", 64'(ids[2]), 64'(2));
    chk("rr_order_3", 64'(ids[3]), 64'(3));
    chk("rr_order_4", 64'(ids[4]), 64'(0));
    repeat (4) @(posedge clk);

    // Response backpressure: outputs held, no grants while waiting.
    #1;
    rsp_ready       = 1'b0;
    req_a[2*32 +: 32] = 32'd10;
    req_b[2*32 +: 32] = 32'd3;
    req_sub[2]      = 1'b1;
    req_valid       = 4'b0100;
    w = 0;
    do begin @(negedge clk); w++; end while (!rsp_valid && w < 20);
    chk("bp_reach_resp", 64'(rsp_valid), 64'(1));
    @(posedge clk); #1;
    req_valid = 4'b1011;
    repeat (10) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_result", 64'(rsp_result), 64'(7));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_valid", 64'(rsp_valid), 64'(1));
    @(posedge clk); #1;
    req_valid  = '0;
    req_sub[2] = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 64'(rsp_valid), 64'(0));
    repeat (2) @(posedge clk);

    // Reset while in EXEC discards the operation and returns the pointer to 0.
    #1;
    req_valid[3] = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready[3] && w < 20);
    @(posedge clk); #1;
    req_valid = '0;
    chk("mid_rst_in_exec", 64'(busy), 64'(1));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
    @(posedge clk); #1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("mid_rst_ptr0", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

`ifdef ADD32_ARB_OVF_STICKY_EN
    // Sticky overflow: set on response, set beats same-cycle clear, clear alone drops it.
    do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, "sticky_set");
    @(negedge clk);
    chk("sticky_bit1", 64'(ovf_sticky[1]), 64'(1));
    @(posedge clk); #1;
    ovf_clr[1] = 1'b1;
    do_op(1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd1, 1'b1, "sticky_setwins");
    ovf_clr[1] = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 64'(ovf_sticky[1]), 64'(1));
    @(posedge clk); #1;
    ovf_clr[1] = 1'b1;
    @(posedge clk); #1;
    ovf_clr[1] = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 64'(ovf_sticky[1]), 64'(0));
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
